// File: rtl/timer_pkg.sv
// Shared types and constants for the two-digit stopwatch control path.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } sw_state_e;

    localparam int CNT_W  = 7;
    localparam int DISP_W = 32;

    // Modulo increment: wraps to zero after reaching the terminal count.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                  input logic [CNT_W-1:0] lim);
        cnt_next = (cur == lim) ? {CNT_W{1'b0}} : cur + CNT_W'(1);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser followed by a rising-edge detector for one push button.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic pulse
);

    logic sync1_r;
    logic sync2_r;
    logic sync2_d_r;

    // Synchroniser chain plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            sync2_d_r <= 1'b0;
        end else begin
            sync1_r   <= btn_in;
            sync2_r   <= sync1_r;
            sync2_d_r <= sync2_r;
        end
    end

    assign pulse = sync2_r & ~sync2_d_r;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing: button FSM, prescaler, modulo count and lap-freeze register.
module stopwatch_ctrl
    import timer_pkg::*;
#(
    parameter int DIV   = 10,
    parameter int LIMIT = 99
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_start,
    input  logic              btn_lap,
    input  logic              btn_clr,
    output logic [DISP_W-1:0] disp_num,
    output logic              running,
    output logic              lap_active,
    output logic              wrap,
    output logic [1:0]        state
);

    localparam int                 PRE_W   = $clog2(DIV);
    localparam logic [PRE_W-1:0]   PRE_MAX = PRE_W'(DIV - 1);
    localparam logic [CNT_W-1:0]   LIM_C   = CNT_W'(LIMIT);

    sw_state_e        state_r;
    sw_state_e        next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] lap_val_r;
    logic [CNT_W-1:0] disp_cnt_s;
    logic [PRE_W-1:0] pre_r;
    logic             wrap_r;
    logic             start_p_s;
    logic             lap_p_s;
    logic             clr_p_s;
    logic             running_s;
    logic             tick_s;
    logic             do_lap_s;
    logic             do_clr_s;

    btn_edge u_start (.clk(clk), .rst_n(rst_n), .btn_in(btn_start), .pulse(start_p_s));
    btn_edge u_lap   (.clk(clk), .rst_n(rst_n), .btn_in(btn_lap),   .pulse(lap_p_s));
    btn_edge u_clr   (.clk(clk), .rst_n(rst_n), .btn_in(btn_clr),   .pulse(clr_p_s));

    assign running_s = (state_r == RUN) || (state_r == LAP);
    assign tick_s    = running_s && (pre_r == PRE_MAX);

    // Next-state decode; a pulse the current state ignores never masks a lower-priority one.
    always_comb begin
        next_state_s = state_r;
        do_lap_s     = 1'b0;
        do_clr_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_p_s) next_state_s = RUN;
                else           next_state_s = IDLE;
            end
            RUN: begin
                if (start_p_s) begin
                    next_state_s = PAUSE;
                end else if (lap_p_s) begin
                    next_state_s = LAP;
                    do_lap_s     = 1'b1;
                end else begin
                    next_state_s = RUN;
                end
            end
            LAP: begin
                if (start_p_s)    next_state_s = PAUSE;
                else if (lap_p_s) next_state_s = RUN;
                else              next_state_s = LAP;
            end
            PAUSE: begin
                if (clr_p_s) begin
                    next_state_s = IDLE;
                    do_clr_s     = 1'b1;
                end else if (start_p_s) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = PAUSE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= next_state_s;
    end

    // Prescaler holds outside RUN/LAP so a resumed run finishes the partial period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         pre_r <= {PRE_W{1'b0}};
        else if (do_clr_s)  pre_r <= {PRE_W{1'b0}};
        else if (tick_s)    pre_r <= {PRE_W{1'b0}};
        else if (running_s) pre_r <= pre_r + PRE_W'(1);
        else                pre_r <= pre_r;
    end

    // Count register and its wrap strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CNT_W{1'b0}};
            wrap_r <= 1'b0;
        end else begin
            if (do_clr_s)    cnt_r <= {CNT_W{1'b0}};
            else if (tick_s) cnt_r <= cnt_next(cnt_r, LIM_C);
            else             cnt_r <= cnt_r;
            wrap_r <= tick_s && (cnt_r == LIM_C);
        end
    end

    // Lap register captures the pre-increment count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        lap_val_r <= {CNT_W{1'b0}};
        else if (do_lap_s) lap_val_r <= cnt_r;
        else               lap_val_r <= lap_val_r;
    end

    assign disp_cnt_s = (state_r == LAP) ? lap_val_r : cnt_r;
    assign disp_num   = {{(DISP_W - CNT_W){1'b0}}, disp_cnt_s};
    assign running    = running_s;
    assign lap_active = (state_r == LAP);
    assign wrap       = wrap_r;
    assign state      = state_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with DIV=4, LIMIT=9; expected values are hand-derived per clock edge.
module tb_stopwatch_ctrl;

    localparam int END_CYC = 252;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_lap = 1'b0;
    logic        btn_clr = 1'b0;
    logic [31:0] disp_num;
    logic        running;
    logic        lap_active;
    logic        wrap;
    logic [1:0]  state;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int          when;
        logic [31:0] disp;
        logic        run;
        logic        lap;
        logic [1:0]  st;
        logic        wr;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;

    stopwatch_ctrl #(.DIV(4), .LIMIT(9)) dut (
        .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_lap(btn_lap),
        .btn_clr(btn_clr), .disp_num(disp_num), .running(running),
        .lap_active(lap_active), .wrap(wrap), .state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic exp_at(input int w, input int d, input logic r, input logic l,
                          input logic [1:0] s, input logic wr);
        exp_t e;
        e.when = w; e.disp = 32'(d); e.run = r; e.lap = l; e.st = s; e.wr = wr;
        sb_q.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic press(input logic s, input logic l, input logic c);
        btn_start = s; btn_lap = l; btn_clr = c;
        @(negedge clk);
        btn_start = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
    endtask

    // Monitor: pops every expectation due at this cycle and compares against the DUT.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].when <= cyc) begin
            cur = sb_q.pop_front();
            n_checks++;
            if (cur.when != cyc || disp_num !== cur.disp || running !== cur.run ||
                lap_active !== cur.lap || state !== cur.st || wrap !== cur.wr) begin
                n_fail++;
                $display("FAIL chk@%0d: got disp=%0d run=%0b lap=%0b st=%0d wrap=%0b (cyc %0d), want disp=%0d run=%0b lap=%0b st=%0d wrap=%0b",
                         cur.when, disp_num, running, lap_active, state, wrap, cyc,
                         cur.disp, cur.run, cur.lap, cur.st, cur.wr);
            end
        end
        if (cyc == END_CYC) begin
            n_checks++;
            if (sb_q.size() != 0) begin
                n_fail++;
                $display("FAIL sb_drain: got %0d pending entries, want 0", sb_q.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    // Stimulus: cycle-scheduled button presses; effects land three edges after a press.
    initial begin
        // reset state, start, steady counting and wrap 9->0
        exp_at(3, 0, 0, 0, 0, 0);
        exp_at(5, 0, 0, 0, 0, 0);
        exp_at(6, 0, 1, 0, 1, 0);
        exp_at(9, 0, 1, 0, 1, 0);
        exp_at(10, 1, 1, 0, 1, 0);
        exp_at(14, 2, 1, 0, 1, 0);
        exp_at(42, 9, 1, 0, 1, 0);
        exp_at(45, 9, 1, 0, 1, 0);
        exp_at(46, 0, 1, 0, 1, 1);
        exp_at(47, 0, 1, 0, 1, 0);
        wait_to(2);
        rst_n = 1'b1;
        wait_to(3);
        press(1'b1, 1'b0, 1'b0);

        // lap freeze at 5 while count runs on, then release at live 8
        exp_at(66, 5, 1, 0, 1, 0);
        exp_at(67, 5, 1, 1, 3, 0);
        exp_at(71, 5, 1, 1, 3, 0);
        exp_at(78, 5, 1, 1, 3, 0);
        exp_at(79, 8, 1, 0, 1, 0);
        exp_at(82, 9, 1, 0, 1, 0);
        exp_at(86, 0, 1, 0, 1, 1);
        wait_to(64);
        press(1'b0, 1'b1, 1'b0);
        wait_to(76);
        press(1'b0, 1'b1, 1'b0);

        // pause at 3 with prescaler at 2, resume finishes the partial period
        exp_at(99, 3, 1, 0, 1, 0);
        exp_at(100, 3, 0, 0, 2, 0);
        exp_at(110, 3, 0, 0, 2, 0);
        exp_at(120, 3, 0, 0, 2, 0);
        exp_at(121, 3, 1, 0, 1, 0);
        exp_at(122, 3, 1, 0, 1, 0);
        exp_at(123, 4, 1, 0, 1, 0);
        exp_at(127, 5, 1, 0, 1, 0);
        exp_at(131, 6, 1, 0, 1, 0);
        exp_at(135, 7, 1, 0, 1, 0);
        wait_to(97);
        press(1'b1, 1'b0, 1'b0);
        wait_to(118);
        press(1'b1, 1'b0, 1'b0);

        // clr beats start in PAUSE and zeroes prescaler; clr ignored in RUN
        exp_at(136, 7, 0, 0, 2, 0);
        exp_at(142, 7, 0, 0, 2, 0);
        exp_at(143, 0, 0, 0, 0, 0);
        exp_at(149, 0, 1, 0, 1, 0);
        exp_at(152, 0, 1, 0, 1, 0);
        exp_at(153, 1, 1, 0, 1, 0);
        exp_at(157, 2, 1, 0, 1, 0);
        wait_to(133);
        press(1'b1, 1'b0, 1'b0);
        wait_to(140);
        press(1'b1, 1'b0, 1'b1);
        wait_to(146);
        press(1'b1, 1'b0, 1'b0);
        wait_to(150);
        press(1'b0, 1'b0, 1'b1);

        // tick coincident with pause, clear, then a held start gives one transition
        exp_at(160, 2, 1, 0, 1, 0);
        exp_at(161, 3, 0, 0, 2, 0);
        exp_at(165, 3, 0, 0, 2, 0);
        exp_at(166, 0, 0, 0, 0, 0);
        exp_at(170, 0, 0, 0, 0, 0);
        exp_at(171, 0, 1, 0, 1, 0);
        exp_at(190, 4, 1, 0, 1, 0);
        exp_at(210, 9, 1, 0, 1, 0);
        exp_at(211, 0, 1, 0, 1, 1);
        exp_at(212, 0, 1, 0, 1, 0);
        exp_at(218, 1, 1, 0, 1, 0);
        exp_at(225, 3, 1, 0, 1, 0);
        exp_at(229, 4, 0, 0, 2, 0);
        wait_to(158);
        press(1'b1, 1'b0, 1'b0);
        wait_to(163);
        press(1'b0, 1'b0, 1'b1);
        wait_to(168);
        btn_start = 1'b1;
        wait_to(218);
        btn_start = 1'b0;
        wait_to(226);
        press(1'b1, 1'b0, 1'b0);

        // lap at 4, count runs to 6, then asynchronous reset between edges
        exp_at(234, 4, 1, 0, 1, 0);
        exp_at(235, 4, 1, 1, 3, 0);
        exp_at(236, 4, 1, 1, 3, 0);
        exp_at(240, 4, 1, 1, 3, 0);
        exp_at(241, 4, 1, 1, 3, 0);
        wait_to(231);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        wait_to(241);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_at(cyc, 0, 0, 0, 0, 0);
        exp_at(247, 0, 0, 0, 0, 0);
        wait_to(245);
        rst_n = 1'b1;
    end

endmodule
